// File: rtl/AhbGlobalPackage.sv
// Shared AHB encodings and slave FSM state type.
package AhbGlobalPackage;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    OKAY = 3'd2,
    ERR1 = 3'd3,
    ERR2 = 3'd4
  } slave_state_t;

  function automatic logic is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// Byte-enabled single-port RAM: synchronous write, combinational read, no reset.
module ahb_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int IDX_W      = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IDX_W-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_wait_state_slave.sv
// AHB-Lite memory slave with a fixed number of wait states and a two-cycle ERROR response.
module ahb_wait_state_slave
  import AhbGlobalPackage::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    hsel,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic                    hexokay
);

  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(BYTES);
  localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W      = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  slave_state_t          state, next_state;
  logic [CNT_W-1:0]      cnt, next_cnt;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic                  accept;
  logic                  bad;
  logic [7:0]            size_bytes;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_we;

  // Address-phase decode; nothing is accepted while a data phase is stalled
  assign size_bytes = 8'd1 << hsize;
  assign word_idx   = haddr >> BYTE_SHIFT;
  assign bad = (word_idx >= ADDR_WIDTH'(MEM_DEPTH))
            || ((haddr & (ADDR_WIDTH'(size_bytes) - ADDR_WIDTH'(1))) != '0)
            || (size_bytes > 8'(BYTES));
  assign accept = hsel && hready && is_active(htrans)
               && (state == IDLE || state == OKAY || state == ERR2);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (accept) begin
        idx_q   <= IDX_W'(word_idx);
        write_q <= hwrite;
      end
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE, OKAY, ERR2: begin
        next_state = IDLE;
        if (accept) begin
          if (bad) begin
            next_state = ERR1;
          end else if (WAIT_STATES > 0) begin
            next_state = WAIT;
            next_cnt   = CNT_W'(WAIT_STATES);
          end else begin
            next_state = OKAY;
          end
        end
      end
      WAIT: begin
        if (cnt <= CNT_W'(1)) begin
          next_state = OKAY;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt - CNT_W'(1);
        end
      end
      ERR1:    next_state = ERR2;
      default: next_state = IDLE;
    endcase
  end

  // Storage is written at the end of the OKAY cycle, so a reset there drops the write too
  assign mem_we    = (state == OKAY) && write_q && !hreset;
  assign hreadyout = !(state == WAIT || state == ERR1);
  assign hresp     = (state == ERR1) || (state == ERR2);
  assign hrdata    = (state == OKAY && !write_q) ? mem_rdata : '0;
  assign hexokay   = 1'b0;

  ahb_slave_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk  (hclk),
    .we   (mem_we),
    .addr (idx_q),
    .wdata(hwdata),
    .wstrb(hwstrb),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_ahb_wait_state_slave.sv
// Scoreboard bench: a WAIT_STATES=2 and a WAIT_STATES=0 slave share one master-side bus.
module tb_ahb_wait_state_slave;
  import AhbGlobalPackage::*;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } stim_t;

  typedef struct {
    logic        err;
    int          waits;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;
  int          target;

  logic        hsel2, hready2, hreadyout2, hresp2, hexokay2;
  logic        hsel0, hready0, hreadyout0, hresp0, hexokay0;
  logic [31:0] hrdata2, hrdata0;
  logic        hreadyout, hresp;
  logic [31:0] hrdata;

  stim_t       stim_q [$];
  exp_t        exp_q [$];
  logic [31:0] model_mem [int];
  int          compared = 0;
  int          mismatched = 0;

  always #5 hclk = ~hclk;

  assign hsel2     = hsel && (target == 0);
  assign hsel0     = hsel && (target == 1);
  assign hready2   = (target == 0) ? hreadyout2 : 1'b1;
  assign hready0   = (target == 1) ? hreadyout0 : 1'b1;
  assign hreadyout = (target == 0) ? hreadyout2 : hreadyout0;
  assign hresp     = (target == 0) ? hresp2 : hresp0;
  assign hrdata    = (target == 0) ? hrdata2 : hrdata0;

  ahb_wait_state_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) dut2 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hwstrb(hwstrb), .hready(hready2),
    .hreadyout(hreadyout2), .hresp(hresp2), .hrdata(hrdata2), .hexokay(hexokay2)
  );

  ahb_wait_state_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hwstrb(hwstrb), .hready(hready0),
    .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0), .hexokay(hexokay0)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] trans, input logic [31:0] addr, input logic write,
                               input logic [2:0] size, input logic [31:0] wdata, input logic [3:0] strb);
    stim_t s;
    s.sel = 1'b1; s.trans = trans; s.addr = addr; s.write = write;
    s.size = size; s.wdata = wdata; s.strb = strb;
    stim_q.push_back(s);
  endtask

  task automatic drive_idle();
    hsel = 1'b0; htrans = HTRANS_IDLE; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
  endtask

  // Present the next queued address phase and record what the slave should answer
  task automatic drive_next();
    stim_t s;
    exp_t  e;
    int    key;
    logic  is_bad;
    logic [31:0] word;
    if (stim_q.size() == 0) begin
      drive_idle();
      return;
    end
    s = stim_q.pop_front();
    hsel = s.sel; htrans = s.trans; haddr = s.addr; hwrite = s.write; hsize = s.size;
    e.err = 1'b0; e.waits = 0; e.rdata = '0; e.wdata = s.wdata; e.strb = s.strb;
    if (s.trans[1]) begin
      is_bad = ((s.addr >> 2) >= 32'd256) || ((s.addr & ((32'd1 << s.size) - 32'd1)) != 32'd0)
            || ((32'd1 << s.size) > 32'd4);
      e.err   = is_bad;
      e.waits = is_bad ? 1 : ((target == 0) ? 2 : 0);
      if (!is_bad) begin
        key  = target * 1024 + int'(s.addr >> 2);
        word = model_mem.exists(key) ? model_mem[key] : 32'd0;
        if (s.write) begin
          for (int b = 0; b < 4; b++) if (s.strb[b]) word[8*b +: 8] = s.wdata[8*b +: 8];
          model_mem[key] = word;
        end else begin
          e.rdata = word;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // Cycle engine: drive on falling edges, accept on the rising edge when hready is high
  task automatic run_bus(input int budget);
    int   cycles = 0;
    logic prev_ready = 1'b0;
    logic dp_active = 1'b0;
    int   dp_waits = 0;
    exp_t dp;
    dp = '{err: 1'b0, waits: 0, rdata: '0, wdata: '0, strb: '0};
    while ((stim_q.size() > 0 || dp_active || hsel) && cycles < budget) begin
      @(negedge hclk);
      cycles++;
      if (prev_ready && hsel) begin
        dp        = exp_q.pop_front();
        dp_active = 1'b1;
        dp_waits  = 0;
        hwdata    = dp.wdata;
        hwstrb    = dp.strb;
      end
      if (dp_active) begin
        if (hreadyout) begin
          checkOutput("resp", hresp, dp.err);
          checkOutput("waits", dp_waits, dp.waits);
          checkOutput("rdata", hrdata, dp.rdata);
          dp_active = 1'b0;
        end else begin
          dp_waits++;
          checkOutput("wait_resp", hresp, dp.err);
          checkOutput("wait_rdata", hrdata, 32'd0);
        end
      end
      prev_ready = hreadyout;
      if (hreadyout) drive_next();
    end
    if (cycles >= budget) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL timeout: bus still busy after %0d cycles, required idle", cycles);
      drive_idle();
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    target = 0;
    hreset = 1'b1;
    hwdata = '0;
    hwstrb = '0;
    drive_idle();
    repeat (2) @(negedge hclk);
    checkOutput("rst_ready2", hreadyout2, 1'b1);
    checkOutput("rst_resp2", hresp2, 1'b0);
    checkOutput("rst_rdata2", hrdata2, 32'd0);
    checkOutput("rst_ready0", hreadyout0, 1'b1);
    checkOutput("rst_resp0", hresp0, 1'b0);
    checkOutput("rst_rdata0", hrdata0, 32'd0);
    checkOutput("hexokay2", hexokay2, 1'b0);
    checkOutput("hexokay0", hexokay0, 1'b0);
    hreset = 1'b0;

    $display("[TB] two wait states: write/read, strobes, errors, pipelining");
    applyStimulus(HTRANS_NONSEQ, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 4'hF);
    applyStimulus(HTRANS_NONSEQ, 32'h10, 1'b0, 3'd2, 32'h0, 4'h0);
    applyStimulus(HTRANS_NONSEQ, 32'h10, 1'b1, 3'd2, 32'h000000AA, 4'h1);
    applyStimulus(HTRANS_NONSEQ, 32'h10, 1'b0, 3'd2, 32'h0, 4'h0);
    applyStimulus(HTRANS_NONSEQ, 32'h00, 1'b1, 3'd2, 32'h11223344, 4'hF);
    applyStimulus(HTRANS_NONSEQ, 32'h400, 1'b0, 3'd2, 32'h0, 4'h0);
    applyStimulus(HTRANS_NONSEQ, 32'h10, 1'b0, 3'd2, 32'h0, 4'h0);
    applyStimulus(HTRANS_NONSEQ, 32'h02, 1'b0, 3'd2, 32'h0, 4'h0);
    applyStimulus(HTRANS_NONSEQ, 32'h02, 1'b1, 3'd2, 32'hFFFFFFFF, 4'hF);
    applyStimulus(HTRANS_NONSEQ, 32'h00, 1'b0, 3'd2, 32'h0, 4'h0);
    applyStimulus(HTRANS_NONSEQ, 32'h08, 1'b0, 3'd3, 32'h0, 4'h0);
    applyStimulus(HTRANS_NONSEQ, 32'h12, 1'b0, 3'd1, 32'h0, 4'h0);
    applyStimulus(HTRANS_IDLE, 32'h14, 1'b0, 3'd2, 32'h0, 4'h0);
    applyStimulus(HTRANS_NONSEQ, 32'h30, 1'b1, 3'd2, 32'hCAFEF00D, 4'hF);
    applyStimulus(HTRANS_NONSEQ, 32'h30, 1'b0, 3'd2, 32'h0, 4'h0);
    run_bus(400);

    $display("[TB] reset during the second wait cycle of a write");
    @(negedge hclk);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
    @(negedge hclk);
    drive_idle();
    hwdata = 32'h12345678;
    hwstrb = 4'hF;
    checkOutput("rst_wait1_ready", hreadyout, 1'b0);
    @(negedge hclk);
    checkOutput("rst_wait2_ready", hreadyout, 1'b0);
    hreset = 1'b1;
    @(negedge hclk);
    hreset = 1'b0;
    checkOutput("rst_after_ready", hreadyout, 1'b1);
    checkOutput("rst_after_resp", hresp, 1'b0);
    applyStimulus(HTRANS_NONSEQ, 32'h30, 1'b0, 3'd2, 32'h0, 4'h0);
    run_bus(100);

    $display("[TB] zero wait states: INCR burst with BUSY, readback, error");
    target = 1;
    applyStimulus(HTRANS_NONSEQ, 32'h20, 1'b1, 3'd2, 32'hA0A0A0A0, 4'hF);
    applyStimulus(HTRANS_SEQ,    32'h24, 1'b1, 3'd2, 32'hB1B1B1B1, 4'hF);
    applyStimulus(HTRANS_BUSY,   32'h28, 1'b1, 3'd2, 32'h0, 4'h0);
    applyStimulus(HTRANS_SEQ,    32'h28, 1'b1, 3'd2, 32'hC2C2C2C2, 4'hF);
    applyStimulus(HTRANS_SEQ,    32'h2C, 1'b1, 3'd2, 32'hD3D3D3D3, 4'hF);
    applyStimulus(HTRANS_NONSEQ, 32'h20, 1'b0, 3'd2, 32'h0, 4'h0);
    applyStimulus(HTRANS_SEQ,    32'h24, 1'b0, 3'd2, 32'h0, 4'h0);
    applyStimulus(HTRANS_SEQ,    32'h28, 1'b0, 3'd2, 32'h0, 4'h0);
    applyStimulus(HTRANS_SEQ,    32'h2C, 1'b0, 3'd2, 32'h0, 4'h0);
    applyStimulus(HTRANS_NONSEQ, 32'h400, 1'b1, 3'd2, 32'h55555555, 4'hF);
    applyStimulus(HTRANS_NONSEQ, 32'h24, 1'b1, 3'd0, 32'h0000EE00, 4'h2);
    applyStimulus(HTRANS_NONSEQ, 32'h24, 1'b0, 3'd2, 32'h0, 4'h0);
    run_bus(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ahb_wait_state_slave.md
AHB_WAIT_STATE_SLAVE -- requirements
Module: ahb_wait_state_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address bus width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data bus width (32 or 64).
REQ-003 SHALL have parameter MEM_DEPTH, default 256, storage depth in DATA_WIDTH words.
REQ-004 SHALL have parameter WAIT_STATES, default 2, inserted wait cycles per OKAY transfer (0..15).
REQ-005 SHALL have port hclk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port hreset, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port hsel, input, 1, slave select from the interconnect's hselx bit.
REQ-008 SHALL have port haddr, input, ADDR_WIDTH, transfer address.
REQ-009 SHALL have port htrans, input, 2, IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-010 SHALL have port hwrite, input, 1, 1 = write.
REQ-011 SHALL have port hsize, input, 3, transfer size.
REQ-012 SHALL have port hwdata, input, DATA_WIDTH, write data.
REQ-013 SHALL have port hwstrb, input, DATA_WIDTH/8, write byte strobes.
REQ-014 SHALL have port hready, input, 1, bus-level ready from the interconnect.
REQ-015 SHALL have port hreadyout, output, 1, slave ready.
REQ-016 SHALL have port hresp, output, 1, 0 = OKAY, 1 = ERROR.
REQ-017 SHALL have port hrdata, output, DATA_WIDTH, read data.
REQ-018 SHALL have port hexokay, output, 1; constant 0 (exclusive access unsupported).

Function
REQ-019 SHALL accept an address phase only when hsel=1, hready=1 and htrans[1]=1, registering haddr, hwrite, hsize and the error check.
REQ-020 SHALL treat IDLE or BUSY with hsel=1 and hready=1 as a zero-wait OKAY: hreadyout=1, hresp=0 in the following cycle.
REQ-021 SHALL use FSM states IDLE, WAIT, OKAY, ERR1, ERR2; IDLE->WAIT on an accepted good transfer with WAIT_STATES>0, else IDLE->OKAY; IDLE->ERR1 on an accepted bad transfer.
REQ-022 SHALL drive hreadyout=0 in WAIT for exactly WAIT_STATES cycles via a down-counter sized $clog2(WAIT_STATES+1), then enter OKAY.
REQ-023 SHALL drive hreadyout=1, hresp=0 in OKAY; from OKAY, go to WAIT, OKAY or ERR1 if a new transfer is accepted that cycle (pipelined back-to-back), else IDLE.
REQ-024 SHALL flag ERROR when word index >= MEM_DEPTH, when haddr is misaligned to hsize, or when 2**hsize > DATA_WIDTH/8.
REQ-025 SHALL drive the two-cycle ERROR response: ERR1 hreadyout=0, hresp=1; ERR2 hreadyout=1, hresp=1; ERR2 returns to IDLE.
REQ-026 SHALL ignore any address phase presented during ERR1 (hready low); a new transfer may be accepted in ERR2.
REQ-027 SHALL sample hwdata in the OKAY cycle of a write and update only the bytes enabled by hwstrb; erroring writes SHALL NOT modify storage.
REQ-028 SHALL present read data on hrdata in the OKAY cycle; hrdata SHALL be 0 in all other cycles.
REQ-029 SHALL return the updated value for a read that immediately follows a write to the same address.

Reset
REQ-030 SHALL, while hreset=1 at a clock edge, force state IDLE, counter 0, hreadyout=1, hresp=0, hrdata=0.
REQ-031 SHALL abandon any in-flight transfer on reset mid-WAIT or mid-ERR, without writing storage.
REQ-032 SHALL leave storage contents undefined after reset; storage is not cleared.

Structure
REQ-033 SHALL take the htrans encodings and the FSM state enum from AhbGlobalPackage.
REQ-034 SHALL implement storage as a sub-module ahb_slave_mem: byte-enabled single-port RAM with a synchronous write and a combinational read.

Verification
REQ-035 SHALL cover WAIT_STATES=2, NONSEQ write 0xDEADBEEF to 0x10 with hwstrb=0xF, then read 0x10 -> each data phase shows 2 cycles hreadyout=0, read returns 0xDEADBEEF.
REQ-036 SHALL cover a write of 0x000000AA to 0x10 with hwstrb=0x1 over 0xDEADBEEF -> readback 0xDEADBEAA.
REQ-037 SHALL cover a read of address 0x400 with MEM_DEPTH=256 -> ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1), storage unchanged.
REQ-038 SHALL cover a word access (hsize=2) at 0x02 -> ERROR response.
REQ-039 SHALL cover WAIT_STATES=0 with a 4-beat INCR write burst and BUSY inserted after beat 2 -> every beat completes with hreadyout=1, BUSY gets a zero-wait OKAY.
REQ-040 SHALL cover hreset asserted during the second WAIT cycle of a write -> next cycle hreadyout=1, hresp=0, target word unchanged.
